// File: rtl/perm_pkg.sv
// Shared definitions for the permutation datapath: lane and coordinate
// types, state encoding and the state geometry (5x5 lanes).
package perm_pkg;

   localparam int LANE_W     = 64;
   localparam int NLANES_MAX = 25;
   localparam int IDX_W      = 5;

   typedef logic [LANE_W-1:0] lane_t;
   typedef logic [2:0]        coord_t;
   typedef logic [IDX_W-1:0]  idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/lane_xy_cnt.sv
// x-fastest 5x5 lane coordinate counter. Walks (0,0),(1,0)..(4,0),(0,1)..(4,4),
// tracking the linear lane index alongside so a caller can learn when the
// current coordinate is the lane at a programmable index.
module lane_xy_cnt
   import perm_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   clr_i,
   input  logic   en_i,
   input  idx_t   last_idx_i,
   output coord_t x_o,
   output coord_t y_o,
   output logic   last_o
);

   coord_t x_q, x_d;
   coord_t y_q, y_d;
   idx_t   idx_q, idx_d;

   // Next coordinate: clear wins over enable; x wraps at 4 and carries into y.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      x_d   = x_q;
      y_d   = y_q;
      idx_d = idx_q;
      if (clr_i) begin
         x_d   = '0;
         y_d   = '0;
         idx_d = '0;
      end else if (en_i) begin
         idx_d = idx_q + 1'b1;
         if (x_q == coord_t'(4)) begin
            x_d = '0;
            y_d = (y_q == coord_t'(4)) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Coordinate and index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q   <= '0;
         y_q   <= '0;
         idx_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         idx_q <= idx_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (idx_q == last_idx_i);

endmodule

// File: rtl/perm_lane_out.sv
// Lane-stream transmitter: on start, reads the first NLANES lanes of the 5x5
// state from a lane memory read port in x-fastest order and streams them on
// pushout/firstout/dout with stopout backpressure. busy stays high while the
// read port is owned, and done pulses once after the last lane is accepted.
module perm_lane_out #(
   parameter int NLANES = 25,
   parameter int LANE_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [2:0]        rx,
   output logic [2:0]        ry,
   input  logic [LANE_W-1:0] rd,
   output logic              pushout,
   input  logic              stopout,
   output logic              firstout,
   output logic [LANE_W-1:0] dout
);

   import perm_pkg::*;

   localparam idx_t LAST_IDX = idx_t'(NLANES - 1);

   state_t              state_q;
   logic                pushout_q;
   logic                firstout_q;
   logic                busy_q;
   logic                done_q;
   logic                last_out_q;   // lane currently in dout is the final one
   logic [LANE_W-1:0]   dout_q;

   logic   le;
   logic   cnt_clr;
   logic   cnt_en;
   logic   cnt_last;
   coord_t cnt_x;
   coord_t cnt_y;

   // The output register may load whenever it is empty or being drained.
   assign le = !pushout_q || !stopout;

   // Read-address control: step to the next lane after each load unless the
   // lane just read is the last one, so the address never touches a lane
   // beyond NLANES; return to (0,0) when the burst finishes.
   always_comb begin
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_en = !cnt_last;
            end
         end
         SEND: begin
            if (le) begin
               if (last_out_q) begin
                  cnt_clr = 1'b1;
               end else begin
                  cnt_en = !cnt_last;
               end
            end
         end
         default: begin
            cnt_clr = 1'b1;
         end
      endcase
   end

   lane_xy_cnt u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .en_i       (cnt_en),
      .last_idx_i (LAST_IDX),
      .x_o        (cnt_x),
      .y_o        (cnt_y),
      .last_o     (cnt_last)
   );

   // Burst FSM with registered stream outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pushout_q  <= 1'b0;
         firstout_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         last_out_q <= 1'b0;
         dout_q     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  dout_q     <= rd;
                  pushout_q  <= 1'b1;
                  firstout_q <= 1'b1;
                  busy_q     <= 1'b1;
                  last_out_q <= cnt_last;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (le) begin
                  if (last_out_q) begin
                     pushout_q  <= 1'b0;
                     firstout_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     last_out_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     dout_q     <= rd;
                     firstout_q <= 1'b0;
                     last_out_q <= cnt_last;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rx       = cnt_x;
   assign ry       = cnt_y;
   assign pushout  = pushout_q;
   assign firstout = firstout_q;
   assign dout     = dout_q;

endmodule

// File: doc/perm_lane_out.md
Name: perm_lane_out

Overview:
- Transmit side of the lane-stream protocol: after a permutation completes, reads the 5x5 lane state from a lane memory read port.
- Streams the lanes on pushout/stopout/firstout/dout, the same handshake the permutation block uses on its input side.
- Sits between the permutation block's result memory and the next consumer (sponge squeeze or the next block's input stage).
- Never writes the memory. Holds busy high while it owns the read port.

Parameters:
NLANES, 25, lanes emitted per burst (1..25; e.g. 17 for a 1088-bit rate squeeze)
LANE_W, 64, lane width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle request: lane memory holds a valid state, begin a burst
busy  output  1  burst in progress; memory contents must not change while high
done  output  1  one-cycle pulse after the last lane is accepted
rx  output  3  lane memory read x, registered
ry  output  3  lane memory read y, registered
rd  input  LANE_W  lane memory read data, combinational from (rx,ry), same cycle
pushout  output  1  dout valid
stopout  input  1  consumer backpressure
firstout  output  1  marks lane (0,0) of a burst
dout  output  LANE_W  lane data, registered

Behaviour:
- Reset (rst=0, async) clears all outputs and state immediately:
  - pushout=0, firstout=0, dout=0, busy=0, done=0.
  - rx=ry=0, lane index=0, state=IDLE.
  - Applies mid-burst too: the burst is abandoned with no done pulse.
- Lane order is x-fastest: (0,0),(1,0)..(4,0),(0,1)..(4,4). The first NLANES lanes are sent.
  - Index i maps to x=i%5, y=i/5, held as x/y counters with x wrap at 4, not by division.
- Transfer occurs on a cycle with pushout=1 and stopout=0.
- Output register load enable: le = !pushout | !stopout.
  - While stopout=1 with pushout=1: dout, firstout, pushout, rx, ry all held stable.
  - No lane is dropped or duplicated.
- States: IDLE, SEND.
  - IDLE: rx=ry=0, busy=0.
    - On start=1: dout<=rd (lane 0,0), pushout<=1, firstout<=1, busy<=1, (rx,ry)<=(1,0), idx<=1, go to SEND.
    - pushout therefore rises 1 cycle after start.
  - SEND, le=1 and idx<NLANES: dout<=rd, pushout<=1, firstout<=0, idx++, advance (rx,ry).
  - SEND, le=1 and idx==NLANES (the last lane transfers this edge): pushout<=0, firstout<=0, busy<=0, done<=1 for one cycle, go to IDLE.
  - SEND, le=0: hold everything.
- Throughput: one lane per cycle with stopout=0. start to done = NLANES+1 cycles.
- start while busy=1 is ignored.
- start in the done cycle (state IDLE) is accepted: back-to-back bursts with a 1-cycle gap in pushout.
- NLANES=1: firstout and the last lane coincide. done follows its acceptance.
- rx/ry stay at the last-read coordinate between loads. After the final lane they return to (0,0) in IDLE.

Decomposition:
- Package perm_pkg:
  - LANE_W=64 and NLANES_MAX=25
  - lane_t (logic [LANE_W-1:0]) and coord_t (logic [2:0])
  - state enum {IDLE, SEND}
  - The package is shared with the permutation block.
- One sub-module is natural: lane_xy_cnt.
  - x-fastest 5x5 coordinate counter with clear, enable, and a last flag at a programmable index.
  - Reusable by the input loader.

Test Plan:
- Memory lane(x,y)=64'h1000*y+x, stopout=0, pulse start:
  - pushout is high for cycles 1..25 after start.
  - dout sequence is 0,1,2,3,4,1000,...,4004. firstout=1 only with dout=0.
  - done pulses at cycle 26, then busy=0.
- Same memory, stopout=1 during cycles 3-6 after start:
  - dout held at 64'h2 (firstout=0) through the stall.
  - Sequence resumes with 64'h3 and has no gaps or repeats. done at cycle 30.
- NLANES=17:
  - Exactly 17 transfers. The last dout is 64'h3001 (x=1,y=3). done 1 cycle after it.
  - Lane (2,3) is never read.
- start pulsed at cycle 10 of a burst:
  - Ignored; the burst completes normally.
  - start in the done cycle begins a second burst with firstout=1 and dout=0 on the next cycle.
- rst=0 asserted at lane 10:
  - pushout, busy, firstout, dout drop to 0 immediately, with no done pulse.
  - After release, start replays from lane (0,0).
- stopout=1 while the last lane (64'h4004) is presented:
  - pushout stays 1 and done stays 0.
  - On stopout=0, one transfer occurs, then done pulses and pushout falls.
